// File: rtl/mult_share_pkg.sv
// Shared widths and helpers for the shared-multiplier arbiter.
package mult_share_pkg;
  localparam int OP_W = 4;
  localparam int P_W  = 8;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) result++;
    return result;
  endfunction
endpackage

// File: rtl/multiplier_4x4.sv
// Combinational 4x4 signed multiplier; the product is exact in 8 bits.
module multiplier_4x4
  import mult_share_pkg::*;
(
  output logic signed [P_W-1:0]  p,
  input  logic signed [OP_W-1:0] a,
  input  logic signed [OP_W-1:0] b
);
  logic signed [P_W-1:0] w_a_ext;
  logic signed [P_W-1:0] w_b_ext;

  // Sign-extend first so the multiply is carried out at full product width.
  assign w_a_ext = P_W'(a);
  assign w_b_ext = P_W'(b);
  assign p       = w_a_ext * w_b_ext;
endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin sharing of one signed 4x4 multiplier among NUM_REQ requesters,
// with a single registered response slot.
//   state   | meaning
//   S_EMPTY | response register free, rsp_valid=0
//   S_FULL  | response register holds a product, rsp_valid=1
module mult_share_arbiter
  import mult_share_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*OP_W-1:0] req_a,
  input  logic [NUM_REQ*OP_W-1:0] req_b,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [P_W-1:0]          rsp_p,
  output logic [ID_W-1:0]         rsp_id
);
  localparam logic [0:0] S_EMPTY = 1'b0;
  localparam logic [0:0] S_FULL  = 1'b1;

  if (ID_W != clog2(NUM_REQ) || NUM_REQ < 2 || NUM_REQ > 8) begin : g_param_check
    $error("mult_share_arbiter: NUM_REQ must be 2..8 and ID_W must equal clog2(NUM_REQ)");
  end

  logic [0:0]            r_state;
  logic [ID_W-1:0]       r_ptr;
  logic [P_W-1:0]        r_p;
  logic [ID_W-1:0]       r_id;

  logic [ID_W-1:0]       w_grant;
  logic [ID_W-1:0]       w_ptr_next;
  logic                  w_can_accept;
  logic                  w_take;
  logic signed [OP_W-1:0] w_op_a;
  logic signed [OP_W-1:0] w_op_b;
  logic signed [P_W-1:0]  w_prod;

  // Walk downwards so the requester closest to the pointer is the last to overwrite.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                               input logic [ID_W-1:0]    ptr);
    logic [ID_W-1:0] pick;
    pick = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      int idx;
      idx = (int'(ptr) + k) % NUM_REQ;
      if (valid[idx]) pick = ID_W'(idx);
    end
    return pick;
  endfunction

  assign rsp_valid    = (r_state == S_FULL);
  assign rsp_p        = r_p;
  assign rsp_id       = r_id;
  assign w_grant      = rr_pick(req_valid, r_ptr);
  assign w_can_accept = !rsp_valid || rsp_ready;
  assign w_take       = (|req_valid) && w_can_accept;
  assign w_ptr_next   = (int'(w_grant) == NUM_REQ - 1) ? '0 : w_grant + 1'b1;

  // rst_n gates the handshake so nothing is offered while the block is held in reset.
  always_comb begin
    req_ready = '0;
    if (w_take && rst_n) req_ready[w_grant] = 1'b1;
  end

  assign w_op_a = req_a[int'(w_grant)*OP_W +: OP_W];
  assign w_op_b = req_b[int'(w_grant)*OP_W +: OP_W];

  multiplier_4x4 u_mult (
    .p (w_prod),
    .a (w_op_a),
    .b (w_op_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_EMPTY;
      r_ptr   <= '0;
      r_p     <= '0;
      r_id    <= '0;
    end else if (w_take) begin
      r_state <= S_FULL;
      r_ptr   <= w_ptr_next;
      r_p     <= w_prod;
      r_id    <= w_grant;
    end else if (rsp_ready) begin
      r_state <= S_EMPTY;
    end
  end
endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter: directed scenarios followed by a randomized
// run, all checked against a behavioural model of the sharing rules.
module tb_mult_share_arbiter;
  import mult_share_pkg::*;

  localparam int N  = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*4-1:0]  req_a = '0;
  logic [N*4-1:0]  req_b = '0;
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  logic [7:0]      rsp_p;
  logic [IW-1:0]   rsp_id;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model of the response slot and the round-robin pointer.
  bit         m_valid;
  logic [7:0] m_p;
  int         m_id;
  int         m_ptr;

  always #5 clk = ~clk;

  mult_share_arbiter #(.NUM_REQ(N), .ID_W(IW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_p     (rsp_p),
    .rsp_id    (rsp_id)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_p     = 8'h00;
    m_id    = 0;
    m_ptr   = 0;
  endtask

  // First valid requester at or after the pointer, wrapping; -1 if none.
  function automatic int model_grant();
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_ptr + k) % N;
      if (req_valid[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [7:0] ref_mul(input int i);
    logic signed [3:0] ta;
    logic signed [3:0] tb;
    int sa;
    int sb;
    ta = req_a[4*i +: 4];
    tb = req_b[4*i +: 4];
    sa = ta;
    sb = tb;
    return 8'(sa * sb);
  endfunction

  task automatic set_op(input int i, input logic [3:0] a, input logic [3:0] b);
    req_a[4*i +: 4] = a;
    req_b[4*i +: 4] = b;
  endtask

  // Called at posedge+1 with inputs driven; checks at negedge, ends at next posedge+1.
  task automatic cycle(output int acc);
    int           g;
    bit           can;
    logic [N-1:0] exp_rdy;
    logic [7:0]   prod;
    @(negedge clk);
    g       = model_grant();
    can     = !m_valid || rsp_ready;
    exp_rdy = '0;
    if (g >= 0 && can) exp_rdy[g] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
    if (m_valid) begin
      chk("rsp_p", 32'(rsp_p), 32'(m_p));
      chk("rsp_id", 32'(rsp_id), m_id);
    end
    acc  = (g >= 0 && can) ? g : -1;
    prod = (acc >= 0) ? ref_mul(acc) : 8'h00;
    @(posedge clk);
    if (acc >= 0) begin
      m_valid = 1'b1;
      m_p     = prod;
      m_id    = acc;
      m_ptr   = (acc + 1) % N;
    end else if (rsp_ready) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  // Pulse reset away from the clock edge; returns at posedge+1 after release.
  task automatic do_reset();
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_async_clear", 32'(rsp_valid), 32'd0);
    chk("rst_no_ready", 32'(req_ready), 32'd0);
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  logic [3:0] t2a [5] = '{4'hF, 4'h8, 4'h8, 4'h0, 4'h4};
  logic [3:0] t2b [5] = '{4'hF, 4'h8, 4'h7, 4'h9, 4'h7};
  logic [7:0] t2p [5] = '{8'h01, 8'h40, 8'hC8, 8'h00, 8'h1C};

  initial begin
    int         acc;
    logic [7:0] hold_p;
    logic [IW-1:0] hold_id;

    model_reset();
    req_valid = '1;
    rsp_ready = 1'b1;
    #12;
    chk("reset_ready", 32'(req_ready), 32'd0);
    chk("reset_valid", 32'(rsp_valid), 32'd0);
    chk("reset_p", 32'(rsp_p), 32'd0);
    chk("reset_id", 32'(rsp_id), 32'd0);
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single request from requester 0.
    set_op(0, 4'd3, 4'd2);
    req_valid = 4'b0001;
    cycle(acc);
    chk("t1_grant", acc, 0);
    req_valid = '0;
    chk("t1_valid", 32'(rsp_valid), 32'd1);
    chk("t1_p", 32'(rsp_p), 32'h06);
    chk("t1_id", 32'(rsp_id), 32'd0);

    // Signed corner products through requester 1.
    for (int i = 0; i < 5; i++) begin
      set_op(1, t2a[i], t2b[i]);
      req_valid = 4'b0010;
      cycle(acc);
      chk("t2_grant", acc, 1);
      chk("t2_p", 32'(rsp_p), 32'(t2p[i]));
    end
    req_valid = '0;
    cycle(acc);

    // All four requesting after reset: strict rotation, back-to-back results.
    do_reset();
    for (int i = 0; i < N; i++) set_op(i, 4'($urandom), 4'($urandom));
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      cycle(acc);
      chk("t3_grant", acc, i);
      chk("t3_valid", 32'(rsp_valid), 32'd1);
      chk("t3_id", 32'(rsp_id), i);
    end

    // Backpressure for three cycles, then no bubble on release.
    rsp_ready = 1'b0;
    hold_p  = rsp_p;
    hold_id = rsp_id;
    for (int i = 0; i < 3; i++) begin
      cycle(acc);
      chk("t4_stall_acc", acc, -1);
      chk("t4_hold_p", 32'(rsp_p), 32'(hold_p));
      chk("t4_hold_id", 32'(rsp_id), 32'(hold_id));
      chk("t4_hold_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    cycle(acc);
    chk("t4_nobubble", acc, 0);
    chk("t4_valid", 32'(rsp_valid), 32'd1);

    // Pointer wrap: after grant 1, req3 wins over req0, pointer ends at 1.
    req_valid = 4'b0010;
    cycle(acc);
    chk("t5_g1", acc, 1);
    req_valid = 4'b1001;
    cycle(acc);
    chk("t5_g3", acc, 3);
    req_valid = 4'b0001;
    cycle(acc);
    chk("t5_g0", acc, 0);
    req_valid = 4'b0011;
    cycle(acc);
    chk("t5_ptr1", acc, 1);

    // Reset while a result is held and requester 2 is pending.
    rsp_ready = 1'b0;
    req_valid = 4'b0100;
    cycle(acc);
    chk("t6_pending", acc, -1);
    chk("t6_full", 32'(rsp_valid), 32'd1);
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    chk("t6_async_clear", 32'(rsp_valid), 32'd0);
    chk("t6_no_ready", 32'(req_ready), 32'd0);
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    req_valid = 4'b0101;
    cycle(acc);
    chk("t6_restart0", acc, 0);
    req_valid = 4'b0100;
    cycle(acc);
    chk("t6_then2", acc, 2);
    req_valid = '0;

    // Randomized traffic; requesters hold their operands until accepted.
    for (int t = 0; t < 400; t++) begin
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
          set_op(i, 4'($urandom), 4'($urandom));
          req_valid[i] = 1'b1;
        end
      end
      cycle(acc);
      if (acc >= 0) req_valid[acc] = 1'b0;
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    cycle(acc);
    chk("final_idle", acc, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
